hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the non-forwarding 5-stage RV32I core. Drives enable/flush of PC,
//  IF/ID and ID/EX registers. Detects RAW hazards between the ID consumer and EX/MEM/WB

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the non-forwarding 5-stage RV32I pipeline: RAW stall counter plus redirect squash.
// Optional HAZARD_PERF_CNT_EN adds stall/flush event counters.
module hazard_ctrl #(
   parameter int unsigned REG_BYPASS = 1,
   parameter int unsigned CNT_W      = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [4:0] id_rs1_addr_i,
   input  logic [4:0] id_rs2_addr_i,
   input  logic       id_rs1_used_i,
   input  logic       id_rs2_used_i,
   input  logic [4:0] ex_rd_addr_i,
   input  logic       ex_rd_wren_i,
   input  logic [4:0] mem_rd_addr_i,
   input  logic       mem_rd_wren_i,
   input  logic [4:0] wb_rd_addr_i,
   input  logic       wb_rd_wren_i,
   input  logic       ex_redirect_i,
   output logic       pc_en_o,
   output logic       if_id_en_o,
   output logic       if_id_flush_o,
   output logic       id_ex_en_o,
   output logic       id_ex_flush_o,
   output logic       stall_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam int unsigned N_EX  = 3 - REG_BYPASS;
   localparam int unsigned N_MEM = 2 - REG_BYPASS;
   localparam int unsigned N_WB  = 1 - REG_BYPASS;

   typedef enum logic {RUN, STALL} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CNT_W-1:0]   need_n;

   function automatic logic src_match(input logic used, input logic [4:0] src,
                                      input logic wren, input logic [4:0] rd);
      return used && (src != 5'd0) && wren && (src == rd);
   endfunction

   // Required stall length; later producers checked last so the longest requirement wins.
   always_comb begin
      need_n = '0;
      if (src_match(id_rs1_used_i, id_rs1_addr_i, wb_rd_wren_i, wb_rd_addr_i) ||
          src_match(id_rs2_used_i, id_rs2_addr_i, wb_rd_wren_i, wb_rd_addr_i))
         need_n = CNT_W'(N_WB);
      if (src_match(id_rs1_used_i, id_rs1_addr_i, mem_rd_wren_i, mem_rd_addr_i) ||
          src_match(id_rs2_used_i, id_rs2_addr_i, mem_rd_wren_i, mem_rd_addr_i))
         need_n = CNT_W'(N_MEM);
      if (src_match(id_rs1_used_i, id_rs1_addr_i, ex_rd_wren_i, ex_rd_addr_i) ||
          src_match(id_rs2_used_i, id_rs2_addr_i, ex_rd_wren_i, ex_rd_addr_i))
         need_n = CNT_W'(N_EX);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Redirect overrides everything; a held consumer behind it is wrong-path anyway.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pc_en_o       = 1'b1;
      if_id_en_o    = 1'b1;
      if_id_flush_o = 1'b0;
      id_ex_en_o    = 1'b1;
      id_ex_flush_o = 1'b0;
      stall_o       = 1'b0;
      if (!rst_i) begin
         if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            cnt_d         = '0;
            state_d       = RUN;
         end else begin
            unique case (state_q)
               RUN: begin
                  if (need_n != '0) begin
                     stall_o       = 1'b1;
                     pc_en_o       = 1'b0;
                     if_id_en_o    = 1'b0;
                     id_ex_flush_o = 1'b1;
                     cnt_d         = need_n - CNT_W'(1);
                     state_d       = (need_n == CNT_W'(1)) ? RUN : STALL;
                  end
               end
               STALL: begin
                  stall_o       = 1'b1;
                  pc_en_o       = 1'b0;
                  if_id_en_o    = 1'b0;
                  id_ex_flush_o = 1'b1;
                  cnt_d         = cnt_q - CNT_W'(1);
                  state_d       = (cnt_q <= CNT_W'(1)) ? RUN : STALL;
               end
               default: state_d = RUN;
            endcase
         end
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_o)       stall_cnt_q <= stall_cnt_q + 32'd1;
         if (ex_redirect_i) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with REG_BYPASS=1 and one with REG_BYPASS=0.
module tb_hazard_ctrl;

   logic       clk, rst;
   logic [4:0] rs1, rs2, ex_rd, mem_rd, wb_rd;
   logic       u1, u2, ex_w, mem_w, wb_w, redir;
   logic       pc1, ife1, iff1, ide1, idf1, st1;
   logic       pc0, ife0, iff0, ide0, idf0, st0;
`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] scnt1, fcnt1, scnt0, fcnt0;
`endif

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.REG_BYPASS(1), .CNT_W(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
      .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_w), .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_w),
      .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_w), .ex_redirect_i(redir),
      .pc_en_o(pc1), .if_id_en_o(ife1), .if_id_flush_o(iff1), .id_ex_en_o(ide1),
      .id_ex_flush_o(idf1), .stall_o(st1)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1)
`endif
   );

   hazard_ctrl #(.REG_BYPASS(0), .CNT_W(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst),
      .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_rs1_used_i(u1), .id_rs2_used_i(u2),
      .ex_rd_addr_i(ex_rd), .ex_rd_wren_i(ex_w), .mem_rd_addr_i(mem_rd), .mem_rd_wren_i(mem_w),
      .wb_rd_addr_i(wb_rd), .wb_rd_wren_i(wb_w), .ex_redirect_i(redir),
      .pc_en_o(pc0), .if_id_en_o(ife0), .if_id_flush_o(iff0), .id_ex_en_o(ide0),
      .id_ex_flush_o(idf0), .stall_o(st0)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt_o(scnt0), .flush_cnt_o(fcnt0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] ex;  logic exw;
      logic [4:0] mem; logic memw;
      logic [4:0] wb;  logic wbw;
      logic       redir;
      int         n1, n0;
   } vec_t;

   vec_t vecs[10];

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, stall}
   localparam logic [5:0] O_RUN   = 6'b110100;
   localparam logic [5:0] O_STALL = 6'b000111;
   localparam logic [5:0] O_REDIR = 6'b111110;

   function automatic logic [5:0] outs1();
      return {pc1, ife1, iff1, ide1, idf1, st1};
   endfunction
   function automatic logic [5:0] outs0();
      return {pc0, ife0, iff0, ide0, idf0, st0};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      rs1 = 5'd0; rs2 = 5'd0; u1 = 1'b0; u2 = 1'b0;
      ex_rd = 5'd0; ex_w = 1'b0; mem_rd = 5'd0; mem_w = 1'b0;
      wb_rd = 5'd0; wb_w = 1'b0; redir = 1'b0;
   endtask

   task automatic apply(input vec_t v);
      rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2;
      ex_rd = v.ex; ex_w = v.exw; mem_rd = v.mem; mem_w = v.memw;
      wb_rd = v.wb; wb_w = v.wbw; redir = v.redir;
   endtask

   function automatic logic [5:0] first_outs(input logic r, input int n);
      if (r) return O_REDIR;
      if (n > 0) return O_STALL;
      return O_RUN;
   endfunction

   task automatic drain(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   initial begin
      int c1, c0;
      vec_t hz;

      //            name        rs1 rs2 u1 u2 ex  exw mem memw wb wbw rd  n1 n0
      vecs[0] = '{"idle",       0,  0,  0, 0, 0,  0,  0,  0,   0, 0,  0,  0, 0};
      vecs[1] = '{"ex_rs1",     5,  0,  1, 0, 5,  1,  0,  0,   0, 0,  0,  2, 3};
      vecs[2] = '{"mem_wb_rs2", 0,  7,  0, 1, 0,  0,  7,  1,   7, 1,  0,  1, 2};
      vecs[3] = '{"x0_ex",      0,  0,  1, 0, 0,  1,  0,  0,   0, 0,  0,  0, 0};
      vecs[4] = '{"unused_rs1", 5,  0,  0, 0, 5,  1,  0,  0,   0, 0,  0,  0, 0};
      vecs[5] = '{"wb_rs1",     3,  0,  1, 0, 0,  0,  0,  0,   3, 1,  0,  0, 1};
      vecs[6] = '{"ex_nowren",  6,  0,  1, 0, 6,  0,  0,  0,   0, 0,  0,  0, 0};
      vecs[7] = '{"mem1_ex2",   9, 10,  1, 1, 10, 1,  9,  1,   0, 0,  0,  2, 3};
      vecs[8] = '{"redir_hz",   5,  0,  1, 0, 5,  1,  0,  0,   0, 0,  1,  0, 0};
      vecs[9] = '{"rs2_only",   4,  8,  0, 1, 4,  1,  4,  1,   4, 1,  0,  0, 0};

      // Reset with hazardous inputs present: inputs must be ignored.
      rst = 1'b1;
      apply(vecs[1]);
      #2;
      chk("reset_outs_b1", 32'(outs1()), 32'(O_RUN));
      chk("reset_outs_b0", 32'(outs0()), 32'(O_RUN));
      @(negedge clk);
      clear_inputs();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         chk({vecs[i].name, "_first_b1"}, 32'(outs1()), 32'(first_outs(vecs[i].redir, vecs[i].n1)));
         chk({vecs[i].name, "_first_b0"}, 32'(outs0()), 32'(first_outs(vecs[i].redir, vecs[i].n0)));
         c1 = st1 ? 1 : 0;
         c0 = st0 ? 1 : 0;
         @(posedge clk);
         #1;
         clear_inputs();
         #1;
         for (int k = 0; k < 5; k++) begin
            if (st1) c1++;
            if (st0) c0++;
            @(posedge clk);
            #1;
         end
         chk({vecs[i].name, "_len_b1"}, 32'(c1), 32'(vecs[i].n1));
         chk({vecs[i].name, "_len_b0"}, 32'(c0), 32'(vecs[i].n0));
      end

      hz = vecs[1];

      // Cycle-by-cycle EX hazard on the bypassing instance: two held cycles then release.
      @(negedge clk);
      apply(hz);
      #1;
      chk("seqA_c1_b1", 32'(outs1()), 32'(O_STALL));
      @(posedge clk);
      #1;
      clear_inputs();
      #1;
      chk("seqA_c2_b1", 32'(outs1()), 32'(O_STALL));
      @(posedge clk);
      #1;
      chk("seqA_c3_b1", 32'(outs1()), 32'(O_RUN));
      drain(3);

      // Reset asserted while the non-bypassing instance sits in STALL with two cycles left.
      @(negedge clk);
      apply(hz);
      #1;
      chk("seqB_c1_b0", 32'(outs0()), 32'(O_STALL));
      @(posedge clk);
      #1;
      chk("seqB_stall_b0", 32'(outs0()), 32'(O_STALL));
      rst = 1'b1;
      #1;
      chk("seqB_inrst_b0", 32'(outs0()), 32'(O_RUN));
      @(negedge clk);
      rst = 1'b0;
      clear_inputs();
      #1;
      chk("seqB_after_b0", 32'(outs0()), 32'(O_RUN));
      @(posedge clk);
      #1;
      chk("seqB_after2_b0", 32'(outs0()), 32'(O_RUN));

      // Redirect while b1 is in STALL with cnt=1 (b0 has cnt=2).
      @(negedge clk);
      apply(hz);
      @(posedge clk);
      #1;
      clear_inputs();
      redir = 1'b1;
      #1;
      chk("seqC_redir_b1", 32'(outs1()), 32'(O_REDIR));
      chk("seqC_redir_b0", 32'(outs0()), 32'(O_REDIR));
      @(posedge clk);
      #1;
      redir = 1'b0;
      c1 = 0;
      c0 = 0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (st1) c1++;
         if (st0) c0++;
         @(posedge clk);
      end
      chk("seqC_nostall_b1", 32'(c1), 32'd0);
      chk("seqC_nostall_b0", 32'(c0), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
      // Event counters: one EX hazard (3 held on b0, 2 on b1) plus one redirect cycle.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("perf_rst_s0", scnt0, 32'd0);
      chk("perf_rst_f0", fcnt0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply(hz);
      @(negedge clk);
      clear_inputs();
      repeat (4) @(negedge clk);
      redir = 1'b1;
      @(negedge clk);
      redir = 1'b0;
      @(negedge clk);
      chk("perf_stall_b0", scnt0, 32'd3);
      chk("perf_flush_b0", fcnt0, 32'd1);
      chk("perf_stall_b1", scnt1, 32'd2);
      chk("perf_flush_b1", fcnt1, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
